alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Command-side front end for the combinational ALU.
- Buffers operation commands in a small FIFO, issues one at a time to the ALU operand/opcode inputs, and captures the ALU result and flags into a registered valid/ready response port.
- Keeps an accumulator holding the last result, so command chains can feed the previous result back as operand A.
- Sits between the command source (sequencer/testbench) and the ALU; the ALU is instantiated beside it at the top level.

Parameters:
- WIDTH, 8, datapath width; must match the ALU WIDTH.
- DEPTH, 4, command FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_opcode  in  3  ALU opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_acc  in  1  1 = replace A with the accumulator at issue.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_opcode  out  3  to ALU opcode.
- alu_result  in  WIDTH  from ALU.
- alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  4  captured {Z,N,C,V}.
- acc_value  out  WIDTH  accumulator contents.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - FIFO empty, state IDLE.
  - alu_a, alu_b, alu_opcode = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_flags = 0, acc = 0, busy = 0.
  - cmd_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards the FIFO contents, the in-flight issue and any pending response. No response is emitted.
- Push:
  - A command is written when cmd_valid && cmd_ready.
  - cmd_ready is deasserted when the FIFO is full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both performed; the count is unchanged.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the issue registers and go to EXEC.
  - Issue registers: alu_a = cmd_acc ? acc : cmd_a; alu_b = cmd_b; alu_opcode = cmd_opcode.
  - EXEC: the ALU output is combinational from the issue registers. At the edge:
    - rsp_result <= alu_result;
    - rsp_flags <= {alu_z, alu_n, alu_c, alu_v};
    - acc <= alu_result;
    - rsp_valid <= 1; go to HOLD.
  - HOLD: rsp_* held stable while rsp_valid && !rsp_ready. On rsp_ready:
    - clear rsp_valid;
    - if the FIFO is non-empty, pop and go to EXEC; else go to IDLE.
- Latency: a command accepted into an empty idle block gives rsp_valid=1 after 3 rising edges, counting the accepting edge.
- Throughput: 1 result per 2 cycles with rsp_ready held high.
- Accumulator hazard: none. The pop that reads acc always happens after the edge that updated acc.
- Opcodes 101..111 are issued unchanged. The ALU returns 0, so acc becomes 0 and Z=1.
- Ordering: responses are strictly in command order. No drops, no duplicates.
- Arithmetic and flags are whatever the ALU produces; this block does no arithmetic.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_NOT=100;
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0;
  - FSM state encoding IDLE/EXEC/HOLD.
- One sub-module, alu_cmd_fifo:
  - parameterised by WIDTH and DEPTH;
  - entry = {cmd_acc, cmd_opcode, cmd_a, cmd_b};
  - full/empty flags, synchronous reset.

Test Plan:
1. Reset: hold rst for 2 cycles -> rsp_valid=0, cmd_ready=1, acc_value=0x00, busy=0, alu_opcode=000.
2. ADD with A=0x7F, B=0x01, rsp_ready=1 -> rsp_valid rises on the 3rd edge; rsp_result=0x80, flags Z0 N1 C0 V1; acc_value=0x80.
3. Accumulate chain -> responses 0x30, then 0x00 with Z1 N0 C1 V0:
   - ADD 0x10+0x20;
   - then SUB with cmd_acc=1, B=0x30.
4. Backpressure with rsp_ready=0, DEPTH=4, push 6 commands:
   - the 1st issues, the FIFO fills with the next 4, and cmd_ready drops before the 6th;
   - rsp_* stay stable while held;
   - releasing rsp_ready drains all 6 results in order, at one per 2 cycles.
5. Reset mid-operation: assert rst during EXEC with 2 entries queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1; no response ever appears.
6. Invalid opcode 111 with A=0x55, B=0xAA -> rsp_result=0x00, flags Z1 N0 C0 V0, acc_value=0x00.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU command front end and its sub-blocks:
//     - ALU opcode encodings (OP_*)
//     - bit positions of the {Z,N,C,V} flags inside a 4-bit flag word
//     - issue FSM state type
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous FIFO holding ALU commands. One entry is the packed word
//   {cmd_acc, cmd_opcode[2:0], cmd_a[WIDTH-1:0], cmd_b[WIDTH-1:0]}.
//   The head entry is always visible on rd_data (show-ahead).
//
//   Ports:
//     clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//     wr_en     - write request; ignored while full
//     wr_data   - entry to write
//     rd_en     - pop request; ignored while empty
//     rd_data   - current head entry
//     full      - DEPTH entries stored
//     empty     - no entries stored
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned ENTRY_W = 2 * WIDTH + 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_wr;
    logic               do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Command-side front end for a combinational ALU. Commands are queued in
//   alu_cmd_fifo, issued one at a time onto registered ALU operand/opcode
//   outputs, and the ALU result/flags are captured into a registered
//   valid/ready response. An accumulator keeps the last result so a command
//   can use it in place of operand A.
//
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     cmd_valid/cmd_ready       - command handshake (cmd_ready = !full)
//     cmd_opcode, cmd_a, cmd_b  - command fields
//     cmd_acc                   - 1: use the accumulator as operand A
//     alu_a, alu_b, alu_opcode  - registered ALU inputs
//     alu_result, alu_z/n/c/v   - ALU outputs (combinational from alu_*)
//     rsp_valid/rsp_ready       - response handshake
//     rsp_result, rsp_flags     - captured result and {Z,N,C,V}
//     acc_value                 - accumulator contents
//     busy                      - FSM not idle or FIFO non-empty
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic               cmd_acc,

    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_opcode,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic               alu_c,
    input  logic               alu_v,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [FLAGS_W-1:0] rsp_flags,

    output logic [WIDTH-1:0]   acc_value,
    output logic               busy
);

    localparam int unsigned ENTRY_W = 2 * WIDTH + 4;

    // FIFO interface
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Unpacked head-of-queue command
    logic               head_acc;
    logic [2:0]         head_opcode;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    // Registered state
    issue_state_e       state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [FLAGS_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;

    assign fifo_wdata = {cmd_acc, cmd_opcode, cmd_a, cmd_b};

    assign head_acc    = fifo_rdata[ENTRY_W-1];
    assign head_opcode = fifo_rdata[ENTRY_W-2 -: 3];
    assign head_a      = fifo_rdata[2*WIDTH-1 -: WIDTH];
    assign head_b      = fifo_rdata[WIDTH-1:0];

    alu_cmd_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_valid),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Issue FSM. A pop always loads the issue registers from the FIFO head;
    // acc_q is read at that point, one edge after the EXEC edge that last
    // wrote it, so chained accumulator commands see the fresh value.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        acc_d        = acc_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = head_acc ? acc_q : head_a;
                    alu_b_d  = head_b;
                    alu_op_d = head_opcode;
                    state_d  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                rsp_result_d         = alu_result;
                rsp_flags_d          = '0;
                rsp_flags_d[FLAG_Z]  = alu_z;
                rsp_flags_d[FLAG_N]  = alu_n;
                rsp_flags_d[FLAG_C]  = alu_c;
                rsp_flags_d[FLAG_V]  = alu_v;
                acc_d                = alu_result;
                rsp_valid_d          = 1'b1;
                state_d              = ST_HOLD;
            end

            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_a_d  = head_acc ? acc_q : head_a;
                        alu_b_d  = head_b;
                        alu_op_d = head_opcode;
                        state_d  = ST_EXEC;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            acc_q        <= acc_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign acc_value  = acc_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
